// File: rtl/output_port_arbiter_6.sv
// Six-input wormhole output-port arbiter.
// Round-robin choice among requesting inputs while idle; the winner keeps the
// output locked until its tail flit is accepted downstream. After the tail the
// search start moves to the input just past the winner, which gives fairness.
// A saturating counter records how many tail flits have been forwarded.
module output_port_arbiter_6 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [5:0]       valid_in,
    input  logic [5:0]       tail_in,
    input  logic             ready_down,
    output logic [5:0]       grant,
    output logic             valid_out,
    output logic             tail_out,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       grant_nxt;
    logic [2:0]       ptr;
    logic [2:0]       ptr_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             tail_xfer;

    // First requesting input at or after 'start', wrapping from 5 back to 0.
    function automatic logic [2:0] rr_pick(input logic [5:0] req, input logic [2:0] start);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = 3'd0;
        found = 1'b0;
        for (int k = 0; k < 6; k++) begin
            idx = (int'(start) + k) % 6;
            if (!found && req[idx]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Index of the single set bit of a one-hot vector.
    function automatic logic [2:0] onehot_idx(input logic [5:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (v[k]) begin
                idx = 3'(k);
            end
        end
        return idx;
    endfunction

    // Input index following the winner, modulo six.
    function automatic logic [2:0] ptr_after(input logic [2:0] winner);
        return (winner == 3'd5) ? 3'd0 : winner + 3'd1;
    endfunction

    // Counter increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Output side: purely from the registered grant and the current inputs.
    always_comb begin
        valid_out = |(grant & valid_in);
        tail_out  = |(grant & valid_in & tail_in);
        busy      = |grant;
        tail_xfer = tail_out & ready_down;
    end

    // Next-state logic: arbitrate when idle, release only on an accepted tail.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        cnt_nxt   = pkt_cnt;
        unique case (state)
            IDLE: begin
                if (|valid_in) begin
                    grant_nxt = 6'd1 << rr_pick(valid_in, ptr);
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (tail_xfer) begin
                    grant_nxt = 6'd0;
                    ptr_nxt   = ptr_after(onehot_idx(grant));
                    cnt_nxt   = sat_inc(pkt_cnt);
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 6'd0;
            end
        endcase
    end

    // State, grant, pointer and counter registers; reset abandons any packet.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            grant   <= 6'd0;
            ptr     <= 3'd0;
            pkt_cnt <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            ptr     <= ptr_nxt;
            pkt_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_output_port_arbiter_6.sv
// Bench for output_port_arbiter_6: directed scenarios plus a random run, all
// compared against a packet-level model (current owner, search start, count).
module tb_output_port_arbiter_6;

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  valid_in;
    logic [5:0]  tail_in;
    logic        ready_down;
    logic [5:0]  grant;
    logic        valid_out;
    logic        tail_out;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic [5:0]  s_grant;
    logic        s_valid_out;
    logic        s_tail_out;
    logic        s_busy;
    logic [1:0]  s_cnt;

    int checks   = 0;
    int failures = 0;

    // Model: owning input (-1 = none), next search start, packets forwarded.
    int m_owner;
    int m_ptr;
    int m_cnt;

    always #5 clk = ~clk;

    output_port_arbiter_6 #(.CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in), .tail_in(tail_in),
        .ready_down(ready_down), .grant(grant), .valid_out(valid_out),
        .tail_out(tail_out), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    output_port_arbiter_6 #(.CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .valid_in(valid_in), .tail_in(tail_in),
        .ready_down(ready_down), .grant(s_grant), .valid_out(s_valid_out),
        .tail_out(s_tail_out), .busy(s_busy), .pkt_cnt(s_cnt)
    );

    function automatic logic [5:0] exp_grant();
        return (m_owner < 0) ? 6'd0 : 6'(1 << m_owner);
    endfunction

    function automatic logic exp_valid();
        return (m_owner >= 0) && valid_in[m_owner];
    endfunction

    function automatic logic exp_tail();
        return (m_owner >= 0) && valid_in[m_owner] && tail_in[m_owner];
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    // Packet-level rules applied to the inputs present in this cycle.
    task automatic model_next();
        bit found;
        found = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < 6; k++) begin
                if (!found && valid_in[(m_ptr + k) % 6]) begin
                    m_owner = (m_ptr + k) % 6;
                    found   = 1;
                end
            end
        end else if (valid_in[m_owner] && tail_in[m_owner] && ready_down) begin
            m_ptr   = (m_owner + 1) % 6;
            m_owner = -1;
            if (m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic advance();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] v, input logic [5:0] t, input logic r);
        valid_in   = v;
        tail_in    = t;
        ready_down = r;
    endtask

    task automatic do_reset();
        drive(6'd0, 6'd0, 1'b0);
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        model_reset();
        drive(6'h3F, 6'h3F, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (grant !== 6'd0) begin failures++; $display("FAIL reset_grant got=%b exp=000000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid_out got=%b exp=0", valid_out); end
        checks++; if (pkt_cnt !== 16'd0) begin failures++; $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt); end
        drive(6'd0, 6'd0, 1'b0);
        rstn = 1'b1;
        advance();
    endtask

    task automatic test_single_flit();
        logic [5:0] want_g [3];
        logic [15:0] want_c [3];
        want_g = '{6'd0, 6'b000100, 6'd0};
        want_c = '{16'd0, 16'd0, 16'd1};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if (c < 2) drive(6'b000100, 6'b000100, 1'b1);
            else       drive(6'd0, 6'd0, 1'b1);
            #1;
            checks++; if (grant !== want_g[c]) begin failures++; $display("FAIL single_grant c=%0d got=%b exp=%b", c, grant, want_g[c]); end
            checks++; if (valid_out !== exp_valid()) begin failures++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, valid_out, exp_valid()); end
            checks++; if (pkt_cnt !== want_c[c]) begin failures++; $display("FAIL single_cnt c=%0d got=%0d exp=%0d", c, pkt_cnt, want_c[c]); end
            advance();
        end
        // Pointer now sits at 3: an all-request cycle must pick input 3.
        drive(6'h3F, 6'h3F, 1'b0);
        advance();
        #1;
        checks++; if (grant !== 6'b001000) begin failures++; $display("FAIL single_ptr3 got=%b exp=001000", grant); end
    endtask

    task automatic test_round_robin();
        logic [5:0] want;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            drive(6'h3F, 6'h3F, 1'b1);
            #1;
            want = (c % 2 == 1) ? 6'(1 << (((c - 1) / 2) % 6)) : 6'd0;
            checks++; if (grant !== want) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, grant, want); end
            checks++; if (tail_out !== exp_tail()) begin failures++; $display("FAIL rr_tail c=%0d got=%b exp=%b", c, tail_out, exp_tail()); end
            if (c == 12) begin
                checks++; if (pkt_cnt !== 16'd6) begin failures++; $display("FAIL rr_cnt got=%0d exp=6", pkt_cnt); end
            end
            advance();
        end
    endtask

    task automatic test_wormhole();
        logic [5:0] want;
        int sent;
        do_reset();
        drive(6'b000001, 6'b000001, 1'b1);
        advance();
        advance();
        drive(6'd0, 6'd0, 1'b1);
        advance();
        sent = 0;
        for (int c = 0; c < 11; c++) begin
            drive(6'b000011, {4'b0000, (sent == 3), 1'b1}, (c % 2 == 0));
            #1;
            want = (c == 0 || c == 9) ? 6'd0 : (c == 10) ? 6'b000001 : 6'b000010;
            checks++; if (grant !== want) begin failures++; $display("FAIL worm_grant c=%0d got=%b exp=%b", c, grant, want); end
            checks++; if (valid_out !== exp_valid()) begin failures++; $display("FAIL worm_valid c=%0d got=%b exp=%b", c, valid_out, exp_valid()); end
            checks++; if (tail_out !== exp_tail()) begin failures++; $display("FAIL worm_tail c=%0d got=%b exp=%b", c, tail_out, exp_tail()); end
            if (valid_out && ready_down && grant[1]) sent++;
            advance();
        end
        checks++; if (pkt_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL worm_cnt got=%0d exp=%0d", pkt_cnt, m_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(6'b010000, 6'b010000, 1'b1);
        advance();
        advance();
        for (int c = 0; c < 2; c++) begin
            drive(6'b000011, 6'b000011, 1'b0);
            #1;
            checks++; if (grant !== exp_grant()) begin failures++; $display("FAIL wrap_grant c=%0d got=%b exp=%b", c, grant, exp_grant()); end
            advance();
        end
        checks++; if (grant !== 6'b000001) begin failures++; $display("FAIL wrap_final got=%b exp=000001", grant); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        drive(6'b000100, 6'b000000, 1'b1);
        advance();
        advance();
        advance();
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        checks++; if (grant !== 6'd0) begin failures++; $display("FAIL midrst_grant got=%b exp=000000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", valid_out); end
        checks++; if (pkt_cnt !== 16'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", pkt_cnt); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive(6'b100100, 6'b100100, 1'b0);
        #1;
        checks++; if (grant !== 6'd0) begin failures++; $display("FAIL midrst_idle got=%b exp=000000", grant); end
        advance();
        checks++; if (grant !== 6'b000100) begin failures++; $display("FAIL midrst_regrant got=%b exp=000100", grant); end
        checks++; if (grant !== exp_grant()) begin failures++; $display("FAIL midrst_model got=%b exp=%b", grant, exp_grant()); end
    endtask

    task automatic test_random();
        logic [5:0] v;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v = 6'($urandom);
            if ($urandom_range(0, 5) == 0) v = 6'd0;
            drive(v, 6'($urandom), 1'($urandom_range(0, 1)));
            #1;
            checks++; if (grant !== exp_grant()) begin failures++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c, grant, exp_grant()); end
            checks++; if (valid_out !== exp_valid()) begin failures++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, valid_out, exp_valid()); end
            checks++; if (tail_out !== exp_tail()) begin failures++; $display("FAIL rand_tail c=%0d got=%b exp=%b", c, tail_out, exp_tail()); end
            checks++; if (busy !== (m_owner >= 0)) begin failures++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, (m_owner >= 0)); end
            checks++; if (pkt_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL rand_cnt c=%0d got=%0d exp=%0d", c, pkt_cnt, m_cnt); end
            checks++; if ($countones(grant) > 1) begin failures++; $display("FAIL rand_onehot c=%0d got=%b exp=at_most_one_bit", c, grant); end
            advance();
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want [5];
        want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int p = 0; p < 5; p++) begin
            drive(6'b000001, 6'b000001, 1'b1);
            advance();
            advance();
            drive(6'd0, 6'd0, 1'b1);
            #1;
            checks++; if (s_cnt !== want[p]) begin failures++; $display("FAIL sat_cnt p=%0d got=%0d exp=%0d", p, s_cnt, want[p]); end
            checks++; if (pkt_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL sat_wide_cnt p=%0d got=%0d exp=%0d", p, pkt_cnt, m_cnt); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_round_robin();
        test_wormhole();
        test_wrap();
        test_reset_mid_packet();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
